// File: rtl/reg_wb_pkg.sv
// Shared types and sizing for the register write-back arbiter.
// REG_WB_FWD_EN (optional macro) adds the decode-stage bypass ports to reg_wb_arbiter.
package reg_wb_pkg;
  localparam int WB_PEND_DEPTH = 4;
  localparam int WB_PTR_W      = $clog2(WB_PEND_DEPTH);

  typedef logic [4:0]  reg_idx_t;
  typedef logic [31:0] word_t;
endpackage

// File: rtl/reg_wb_tag_fifo.sv
// In-order FIFO of destination indices for issued long-latency ops.
// Push while full and pop while empty are silently dropped.
module reg_wb_tag_fifo
  import reg_wb_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     push,
  input  reg_idx_t push_idx,
  input  logic     pop,
  output reg_idx_t head,
  output logic     full,
  output logic     empty
);
  reg_idx_t              mem_q [WB_PEND_DEPTH];
  reg_idx_t              mem_d [WB_PEND_DEPTH];
  logic [WB_PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [WB_PTR_W:0]     count_q, count_d;
  logic                  push_ok, pop_ok;

  assign full    = (count_q == (WB_PTR_W+1)'(WB_PEND_DEPTH));
  assign empty   = (count_q == '0);
  assign head    = mem_q[rd_ptr_q];
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_idx;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop_ok) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
endmodule

// File: rtl/reg_wb_arbiter.sv
// Register-file write-back arbiter: load completions, an ALU skid entry and new ALU results share one write port.
// Define REG_WB_FWD_EN to add rf_rs*/fwd_rs* bypass of the registered write onto decode operands.
module reg_wb_arbiter
  import reg_wb_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_valid,
  output logic        alu_ready,
  input  reg_idx_t    alu_wa,
  input  word_t       alu_wd,
  input  logic        ld_issue,
  input  reg_idx_t    ld_issue_rd,
  output logic        ld_issue_ready,
  input  logic        ld_valid,
  input  word_t       ld_wd,
  output logic        rf_en,
  output reg_idx_t    rf_wa,
  output word_t       rf_wd,
  output logic [31:0] busy,
  input  reg_idx_t    hz_adr1,
  input  reg_idx_t    hz_adr2,
`ifdef REG_WB_FWD_EN
  input  word_t       rf_rs1,
  input  word_t       rf_rs2,
  output word_t       fwd_rs1,
  output word_t       fwd_rs2,
`endif
  output logic        hz_stall
);
  logic [31:0] busy_q, busy_d;
  logic        skid_valid_q, skid_valid_d;
  reg_idx_t    skid_wa_q, skid_wa_d;
  word_t       skid_wd_q, skid_wd_d;
  logic        rf_en_q, rf_en_d;
  reg_idx_t    rf_wa_q, rf_wa_d;
  word_t       rf_wd_q, rf_wd_d;

  logic        fifo_full, fifo_empty;
  reg_idx_t    fifo_head;
  logic        alu_fire, issue_fire, ld_fire;
  logic        sel_valid;
  reg_idx_t    sel_wa;
  word_t       sel_wd;

  assign alu_ready      = !skid_valid_q && (alu_wa == '0 || !busy_q[alu_wa]);
  assign ld_issue_ready = !fifo_full && (ld_issue_rd == '0 || !busy_q[ld_issue_rd]);
  assign alu_fire       = alu_valid && alu_ready;
  assign issue_fire     = ld_issue && ld_issue_ready;
  assign ld_fire        = ld_valid && !fifo_empty;

  reg_wb_tag_fifo u_tag_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (issue_fire),
    .push_idx (ld_issue_rd),
    .pop      (ld_fire),
    .head     (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  always_comb begin
    skid_valid_d = skid_valid_q;
    skid_wa_d    = skid_wa_q;
    skid_wd_d    = skid_wd_q;
    sel_valid    = 1'b0;
    sel_wa       = '0;
    sel_wd       = '0;
    if (ld_fire) begin
      sel_valid = 1'b1;
      sel_wa    = fifo_head;
      sel_wd    = ld_wd;
      // A result accepted while the load owns the port parks in the skid.
      if (alu_fire) begin
        skid_valid_d = 1'b1;
        skid_wa_d    = alu_wa;
        skid_wd_d    = alu_wd;
      end
    end else if (skid_valid_q) begin
      sel_valid    = 1'b1;
      sel_wa       = skid_wa_q;
      sel_wd       = skid_wd_q;
      skid_valid_d = 1'b0;
    end else if (alu_fire) begin
      sel_valid = 1'b1;
      sel_wa    = alu_wa;
      sel_wd    = alu_wd;
    end

    rf_en_d = sel_valid && (sel_wa != '0);
    rf_wa_d = sel_valid ? sel_wa : rf_wa_q;
    rf_wd_d = sel_valid ? sel_wd : rf_wd_q;

    // Clear before set so a same-edge re-issue keeps the register busy.
    busy_d = busy_q;
    if (ld_fire) busy_d[fifo_head] = 1'b0;
    if (issue_fire) busy_d[ld_issue_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q       <= '0;
      skid_valid_q <= 1'b0;
      skid_wa_q    <= '0;
      skid_wd_q    <= '0;
      rf_en_q      <= 1'b0;
      rf_wa_q      <= '0;
      rf_wd_q      <= '0;
    end else begin
      busy_q       <= busy_d;
      skid_valid_q <= skid_valid_d;
      skid_wa_q    <= skid_wa_d;
      skid_wd_q    <= skid_wd_d;
      rf_en_q      <= rf_en_d;
      rf_wa_q      <= rf_wa_d;
      rf_wd_q      <= rf_wd_d;
    end
  end

  assign rf_en    = rf_en_q;
  assign rf_wa    = rf_wa_q;
  assign rf_wd    = rf_wd_q;
  assign busy     = busy_q;
  assign hz_stall = (hz_adr1 != '0 && busy_q[hz_adr1]) || (hz_adr2 != '0 && busy_q[hz_adr2]);

`ifdef REG_WB_FWD_EN
  assign fwd_rs1 = (rf_en_q && rf_wa_q == hz_adr1 && hz_adr1 != '0) ? rf_wd_q : rf_rs1;
  assign fwd_rs2 = (rf_en_q && rf_wa_q == hz_adr2 && hz_adr2 != '0) ? rf_wd_q : rf_rs2;
`endif
endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Directed vector table plus hand-written corner sequences for reg_wb_arbiter.
// Bypass checks run only when REG_WB_FWD_EN is defined.
module tb_reg_wb_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid, alu_ready;
  logic [4:0]  alu_wa;
  logic [31:0] alu_wd;
  logic        ld_issue, ld_issue_ready;
  logic [4:0]  ld_issue_rd;
  logic        ld_valid;
  logic [31:0] ld_wd;
  logic        rf_en;
  logic [4:0]  rf_wa;
  logic [31:0] rf_wd;
  logic [31:0] busy;
  logic [4:0]  hz_adr1, hz_adr2;
  logic        hz_stall;
`ifdef REG_WB_FWD_EN
  logic [31:0] rf_rs1, rf_rs2, fwd_rs1, fwd_rs2;
`endif

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  reg_wb_arbiter dut (
    .clk            (clk),
    .rst            (rst),
    .alu_valid      (alu_valid),
    .alu_ready      (alu_ready),
    .alu_wa         (alu_wa),
    .alu_wd         (alu_wd),
    .ld_issue       (ld_issue),
    .ld_issue_rd    (ld_issue_rd),
    .ld_issue_ready (ld_issue_ready),
    .ld_valid       (ld_valid),
    .ld_wd          (ld_wd),
    .rf_en          (rf_en),
    .rf_wa          (rf_wa),
    .rf_wd          (rf_wd),
    .busy           (busy),
    .hz_adr1        (hz_adr1),
    .hz_adr2        (hz_adr2),
`ifdef REG_WB_FWD_EN
    .rf_rs1         (rf_rs1),
    .rf_rs2         (rf_rs2),
    .fwd_rs1        (fwd_rs1),
    .fwd_rs2        (fwd_rs2),
`endif
    .hz_stall       (hz_stall)
  );

  typedef struct {
    logic        av;
    logic [4:0]  awa;
    logic [31:0] awd;
    logic        li;
    logic [4:0]  lrd;
    logic        lv;
    logic [31:0] lwd;
    logic [4:0]  a1, a2;
    logic        e_ardy, e_irdy, e_stall, e_en;
    logic [4:0]  e_wa;
    logic [31:0] e_wd, e_busy;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(logic av, logic [4:0] awa, logic [31:0] awd,
                              logic li, logic [4:0] lrd, logic lv, logic [31:0] lwd,
                              logic [4:0] a1, logic [4:0] a2,
                              logic e_ardy, logic e_irdy, logic e_stall,
                              logic e_en, logic [4:0] e_wa, logic [31:0] e_wd,
                              logic [31:0] e_busy);
    vec_t v;
    v.av = av; v.awa = awa; v.awd = awd; v.li = li; v.lrd = lrd;
    v.lv = lv; v.lwd = lwd; v.a1 = a1; v.a2 = a2;
    v.e_ardy = e_ardy; v.e_irdy = e_irdy; v.e_stall = e_stall;
    v.e_en = e_en; v.e_wa = e_wa; v.e_wd = e_wd; v.e_busy = e_busy;
    return v;
  endfunction

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
  endfunction

  task automatic idle_inputs();
    alu_valid = 0; alu_wa = 0; alu_wd = 0;
    ld_issue = 0; ld_issue_rd = 0; ld_valid = 0; ld_wd = 0;
    hz_adr1 = 0; hz_adr2 = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle_inputs();
`ifdef REG_WB_FWD_EN
    rf_rs1 = 0; rf_rs2 = 0;
`endif
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_rf_en", rf_en, 0);
    chk("reset_rf_wa", rf_wa, 0);
    chk("reset_rf_wd", rf_wd, 0);
    chk("reset_busy", busy, 0);
    chk("reset_alu_ready", alu_ready, 1);
    chk("reset_issue_ready", ld_issue_ready, 1);
    chk("reset_hz_stall", hz_stall, 0);
    rst = 0;

    //          av awa awd           li lrd lv lwd           a1 a2 ardy irdy stl en wa wd            busy
    vt.push_back(mk(0, 0, 0,            0, 0, 0, 0,            0, 0, 1, 1, 0, 0, 0, 0,            32'h0));
    vt.push_back(mk(1, 5, 32'hDEADBEEF, 0, 0, 0, 0,            0, 0, 1, 1, 0, 1, 5, 32'hDEADBEEF, 32'h0));
    vt.push_back(mk(0, 0, 0,            1, 7, 0, 0,            0, 0, 1, 1, 0, 0, 0, 0,            32'h80));
    vt.push_back(mk(1, 3, 32'h00000333, 0, 0, 1, 32'h12345678, 0, 0, 1, 1, 0, 1, 7, 32'h12345678, 32'h0));
    vt.push_back(mk(0, 0, 0,            0, 0, 0, 0,            0, 0, 0, 1, 0, 1, 3, 32'h00000333, 32'h0));
    vt.push_back(mk(1, 0, 32'hFFFFFFFF, 0, 0, 0, 0,            0, 0, 1, 1, 0, 0, 0, 0,            32'h0));
    vt.push_back(mk(0, 0, 0,            0, 0, 1, 32'h00000BAD, 0, 0, 1, 1, 0, 0, 0, 0,            32'h0));
    vt.push_back(mk(0, 0, 0,            1, 9, 0, 0,            0, 0, 1, 1, 0, 0, 0, 0,            32'h200));
    vt.push_back(mk(1, 9, 32'h00000009, 1, 9, 0, 0,            9, 0, 0, 0, 1, 0, 0, 0,            32'h200));
    vt.push_back(mk(0, 0, 0,            0, 0, 0, 0,            0, 9, 1, 1, 1, 0, 0, 0,            32'h200));
    vt.push_back(mk(0, 0, 0,            0, 0, 1, 32'h00000099, 0, 0, 1, 1, 0, 1, 9, 32'h00000099, 32'h0));
    vt.push_back(mk(0, 0, 0,            1, 1, 0, 0,            0, 0, 1, 1, 0, 0, 0, 0,            32'h2));
    vt.push_back(mk(0, 0, 0,            1, 2, 0, 0,            0, 0, 1, 1, 0, 0, 0, 0,            32'h6));
    vt.push_back(mk(0, 0, 0,            1, 3, 0, 0,            0, 0, 1, 1, 0, 0, 0, 0,            32'hE));
    vt.push_back(mk(0, 0, 0,            1, 4, 0, 0,            0, 0, 1, 1, 0, 0, 0, 0,            32'h1E));
    vt.push_back(mk(0, 0, 0,            1, 5, 0, 0,            0, 0, 1, 0, 0, 0, 0, 0,            32'h1E));
    vt.push_back(mk(0, 0, 0,            0, 0, 1, 32'h00001111, 0, 0, 1, 0, 0, 1, 1, 32'h00001111, 32'h1C));
    vt.push_back(mk(0, 0, 0,            0, 0, 1, 32'h00002222, 0, 0, 1, 1, 0, 1, 2, 32'h00002222, 32'h18));
    vt.push_back(mk(0, 0, 0,            0, 0, 1, 32'h00003333, 0, 0, 1, 1, 0, 1, 3, 32'h00003333, 32'h10));
    vt.push_back(mk(1, 6, 32'h00000066, 0, 0, 1, 32'h00004444, 0, 0, 1, 1, 0, 1, 4, 32'h00004444, 32'h0));
    vt.push_back(mk(0, 0, 0,            0, 0, 0, 0,            0, 0, 0, 1, 0, 1, 6, 32'h00000066, 32'h0));

    foreach (vt[i]) begin
      alu_valid = vt[i].av; alu_wa = vt[i].awa; alu_wd = vt[i].awd;
      ld_issue = vt[i].li; ld_issue_rd = vt[i].lrd;
      ld_valid = vt[i].lv; ld_wd = vt[i].lwd;
      hz_adr1 = vt[i].a1; hz_adr2 = vt[i].a2;
      #1;
      chk($sformatf("v%0d_alu_ready", i), alu_ready, vt[i].e_ardy);
      chk($sformatf("v%0d_issue_ready", i), ld_issue_ready, vt[i].e_irdy);
      chk($sformatf("v%0d_hz_stall", i), hz_stall, vt[i].e_stall);
      step();
      chk($sformatf("v%0d_rf_en", i), rf_en, vt[i].e_en);
      if (vt[i].e_en) begin
        chk($sformatf("v%0d_rf_wa", i), rf_wa, vt[i].e_wa);
        chk($sformatf("v%0d_rf_wd", i), rf_wd, vt[i].e_wd);
      end
      chk($sformatf("v%0d_busy", i), busy, vt[i].e_busy);
      $display("vec %0d: rf_en=%0d rf_wa=%0d rf_wd=0x%08h busy=0x%08h", i, rf_en, rf_wa, rf_wd, busy);
    end

    // Load completion outranks a waiting skid entry.
    idle_inputs();
    ld_issue = 1; ld_issue_rd = 20; step();
    ld_issue_rd = 21; step();
    ld_issue = 0; ld_valid = 1; ld_wd = 32'h20; alu_valid = 1; alu_wa = 22; alu_wd = 32'h22; step();
    chk("prio_first_load_wa", rf_wa, 20);
    alu_valid = 0; ld_wd = 32'h21; step();
    chk("prio_load_over_skid_wa", rf_wa, 21);
    chk("prio_load_over_skid_wd", rf_wd, 32'h21);
    ld_valid = 0; step();
    chk("prio_skid_drain_en", rf_en, 1);
    chk("prio_skid_drain_wa", rf_wa, 22);
    $display("seq prio: final rf_wa=%0d rf_wd=0x%08h busy=0x%08h", rf_wa, rf_wd, busy);

    // Asynchronous reset with two loads pending and the skid occupied.
    idle_inputs();
    ld_issue = 1; ld_issue_rd = 10; step();
    ld_issue_rd = 11; step();
    ld_issue_rd = 12; ld_valid = 1; ld_wd = 32'hAAAA; alu_valid = 1; alu_wa = 13; alu_wd = 32'hD; step();
    idle_inputs();
    #1;
    chk("pre_rst_skid_full", alu_ready, 0);
    chk("pre_rst_busy", busy, 32'h1800);
    chk("pre_rst_rf_en", rf_en, 1);
    #1 rst = 1;
    #1;
    chk("mid_rst_rf_en", rf_en, 0);
    chk("mid_rst_rf_wa", rf_wa, 0);
    chk("mid_rst_rf_wd", rf_wd, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_alu_ready", alu_ready, 1);
    step();
    rst = 0;
    alu_wa = 13; ld_issue_rd = 11; ld_valid = 1; ld_wd = 32'h55;
    #1;
    chk("post_rst_alu_ready", alu_ready, 1);
    chk("post_rst_issue_ready", ld_issue_ready, 1);
    step();
    chk("post_rst_ld_ignored_en", rf_en, 0);
    chk("post_rst_busy", busy, 0);
    ld_valid = 0; step();
    chk("post_rst_skid_gone_en", rf_en, 0);
    $display("seq reset: rf_en=%0d busy=0x%08h", rf_en, busy);

`ifdef REG_WB_FWD_EN
    idle_inputs();
    alu_valid = 1; alu_wa = 4; alu_wd = 32'hA5; step();
    alu_valid = 0; hz_adr2 = 4; hz_adr1 = 0; rf_rs2 = 32'h1234; rf_rs1 = 32'h77;
    #1;
    chk("fwd_rs2_bypass", fwd_rs2, 32'hA5);
    chk("fwd_rs1_x0_raw", fwd_rs1, 32'h77);
    $display("seq fwd: fwd_rs1=0x%08h fwd_rs2=0x%08h", fwd_rs1, fwd_rs2);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/reg_wb_arbiter.md
REG_WB_ARBITER -- requirements
Module: reg_wb_arbiter

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock.
REQ-002 SHALL have ports: rst  in  1  asynchronous active-high reset.
REQ-003 SHALL have ports: alu_valid  in  1  single-cycle result offered; alu_ready  out  1  result accepted this cycle.
REQ-004 SHALL have ports: alu_wa  in  5  destination register; alu_wd  in  32  result data.
REQ-005 SHALL have ports: ld_issue  in  1  long-latency op issued; ld_issue_rd  in  5  its destination; ld_issue_ready  out  1  issue accepted.
REQ-006 SHALL have ports: ld_valid  in  1  oldest pending long op completes; ld_wd  in  32  its data.
REQ-007 SHALL have ports: rf_en  out  1, rf_wa  out  5, rf_wd  out  32  register-file write port, all registered.
REQ-008 SHALL have ports: busy  out  32  per-register pending-write scoreboard; hz_adr1, hz_adr2  in  5 each  decode-stage sources; hz_stall  out  1.
REQ-009 SHALL have ports (WB_FWD_EN only): rf_rs1, rf_rs2  in  32 each  raw register-file reads; fwd_rs1, fwd_rs2  out  32 each  bypassed operands.

Function
REQ-010 SHALL keep a pending-tag FIFO of WB_PEND_DEPTH=4 destination indices, in issue order.
REQ-011 SHALL assert ld_issue_ready = FIFO not full AND (ld_issue_rd==0 OR busy[ld_issue_rd]==0); ld_issue with ready low is ignored.
REQ-012 SHALL on accepted issue push ld_issue_rd and set busy[rd] next edge; rd=0 is pushed but never sets busy.
REQ-013 SHALL ignore ld_valid when the FIFO is empty (no write, no state change).
REQ-014 SHALL keep a one-entry ALU skid buffer; alu_ready = skid empty AND (alu_wa==0 OR busy[alu_wa]==0).
REQ-015 SHALL per cycle select one write source with priority: load completion > skid entry > new accepted ALU result.
REQ-016 SHALL, when the load wins and an ALU result is accepted the same cycle, capture the ALU result into the skid.
REQ-017 SHALL register the selected write: rf_en/rf_wa/rf_wd valid the edge after selection (latency 1); rf_en=0 when no source or the target is x0.
REQ-018 SHALL on load completion pop the FIFO head and clear busy[head] on the same edge rf_en is driven.
REQ-019 SHALL, on same-edge pop of rd and accepted issue to the same rd, leave busy[rd]=1 (set wins).
REQ-020 SHALL drive hz_stall = busy[hz_adr1] OR busy[hz_adr2], combinational, with busy[0] forced 0.

Reset
REQ-021 SHALL on rst asynchronously clear FIFO, skid, busy, rf_en, rf_wa, rf_wd to 0; alu_ready and ld_issue_ready follow REQ-011/014 from cleared state.
REQ-022 SHALL discard in-flight pending loads and skid contents when rst asserts mid-operation; completions after reset release are ignored if FIFO empty.

Configuration
REQ-023 SHALL with macro REG_WB_FWD_EN defined: fwd_rsN = rf_wd when rf_en AND rf_wa==hz_adrN AND hz_adrN!=0, else rf_rsN.
REQ-024 SHALL without REG_WB_FWD_EN omit rf_rs*/fwd_rs* ports and all bypass logic; hz_stall unchanged.

Structure
REQ-025 SHALL place WB_PEND_DEPTH, register-index typedef (5 bits) and data-word typedef (32 bits) in shared package reg_wb_pkg.
REQ-026 SHALL implement the pending-tag FIFO as sub-module reg_wb_tag_fifo (push, pop, head, full, empty).

Verification
REQ-027 SHALL cover: ALU valid wa=5 wd=0xDEADBEEF, no load -> next edge rf_en=1 rf_wa=5 rf_wd=0xDEADBEEF.
REQ-028 SHALL cover: issue rd=7, then ld_valid wd=0x12345678 with ALU wa=3 same cycle -> edge1 write r7, edge2 write r3 from skid, busy[7] cleared at edge1.
REQ-029 SHALL cover: four issues rd=1..4 -> ld_issue_ready=0, fifth ignored; completions write r1,r2,r3,r4 in order.
REQ-030 SHALL cover: busy[9]=1, alu_wa=9 or ld_issue_rd=9 -> alu_ready=0 / ld_issue_ready=0; hz_adr1=9 -> hz_stall=1.
REQ-031 SHALL cover: ALU wa=0 wd=0xFFFFFFFF -> rf_en stays 0; ld_valid with FIFO empty -> no write.
REQ-032 SHALL cover: rst mid-operation with 2 pending and skid full -> all outputs 0, busy=0; with REG_WB_FWD_EN, rf_en wa=4 wd=0xA5 and hz_adr2=4 -> fwd_rs2=0xA5.
